regfile_2w2r_sb: RTL and testbench

- Parametrised successor to the pipeline's single-write register file.
- Configurable data width and depth; optional hardwired zero register.
- Two write ports with fixed priority, two read ports with optional write-to-read bypass.
- Per-register busy scoreboard so the ID stage can detect RAW hazards against in-flight producers (EX/MEM writeback on port 0, load/MUL writeback on port 1).

---
 rtl/regfile_2w2r_sb.sv | 189 ++++++++++++++++++
 tb/tb_regfile_2w2r_sb.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_2w2r_sb.sv
// -----------------------------------------------------------------------------
// regfile_2w2r_sb
//
// Register file with two write ports, two combinational read ports and a
// per-register busy scoreboard for RAW hazard detection in the ID stage.
//
// Write port 0 carries EX/MEM writeback and write port 1 carries load/MUL
// writeback. When both ports target the same register in one cycle, port 1
// wins. Reads can optionally forward same-cycle write data (BYPASS). Register 0
// can optionally be hardwired to zero (ZERO_REG).
//
// Ports
//   clk          rising-edge clock
//   rst          asynchronous active-high reset (clears array and scoreboard)
//   we0/waddr0/wdata0   write port 0 (lower priority)
//   we1/waddr1/wdata1   write port 1 (higher priority)
//   raddr_a/rdata_a     read port A (Rs), combinational
//   raddr_b/rdata_b     read port B (Rt), combinational
//   issue_valid/issue_addr  marks a destination register as having a
//                           pending producer
//   busy_a/busy_b       pending-producer flag for raddr_a/raddr_b
//   any_busy            OR of all registered busy bits
// -----------------------------------------------------------------------------
module regfile_2w2r_sb #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we0,
    input  logic [ADDR_W-1:0] waddr0,
    input  logic [DATA_W-1:0] wdata0,
    input  logic              we1,
    input  logic [ADDR_W-1:0] waddr1,
    input  logic [DATA_W-1:0] wdata1,
    input  logic [ADDR_W-1:0] raddr_a,
    output logic [DATA_W-1:0] rdata_a,
    input  logic [ADDR_W-1:0] raddr_b,
    output logic [DATA_W-1:0] rdata_b,
    input  logic              issue_valid,
    input  logic [ADDR_W-1:0] issue_addr,
    output logic              busy_a,
    output logic              busy_b,
    output logic              any_busy
);

    localparam int   DEPTH = 1 << ADDR_W;
    localparam logic ZR    = (ZERO_REG != 0);
    localparam logic BP    = (BYPASS != 0);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DEPTH-1:0]  busy;
    logic [DEPTH-1:0]  busy_nxt;

    // Effective write enables: writes to the hardwired zero register are
    // dropped so that r0 never changes and never clears a busy bit it
    // could not have had.
    logic wr0_ok;
    logic wr1_ok;
    logic same_addr;

    always_comb begin
        wr0_ok    = we0 && !(ZR && (waddr0 == '0));
        wr1_ok    = we1 && !(ZR && (waddr1 == '0));
        same_addr = (waddr0 == waddr1);
    end

    // ---------------------------------------------------------------------
    // Storage array
    // ---------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            // Port 0 is skipped on a collision so port 1 data is kept.
            if (wr0_ok && !(wr1_ok && same_addr)) begin
                mem[waddr0] <= wdata0;
            end
            if (wr1_ok) begin
                mem[waddr1] <= wdata1;
            end
        end
    end

    // ---------------------------------------------------------------------
    // Scoreboard next-state: set (issue) beats clear (writeback), because a
    // newly issued producer supersedes the one completing this cycle.
    // ---------------------------------------------------------------------
    always_comb begin
        busy_nxt = busy;
        for (int i = 0; i < DEPTH; i++) begin
            logic [ADDR_W-1:0] idx;
            logic              set_i;
            logic              clr_i;
            idx   = i[ADDR_W-1:0];
            set_i = issue_valid && (issue_addr == idx);
            clr_i = (we0 && (waddr0 == idx)) || (we1 && (waddr1 == idx));
            if (ZR && (i == 0)) begin
                busy_nxt[i] = 1'b0;
            end else if (set_i) begin
                busy_nxt[i] = 1'b1;
            end else if (clr_i) begin
                busy_nxt[i] = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy <= '0;
        end else begin
            busy <= busy_nxt;
        end
    end

    // ---------------------------------------------------------------------
    // Read ports
    // ---------------------------------------------------------------------
    logic hit0_a;
    logic hit1_a;
    logic hit0_b;
    logic hit1_b;

    always_comb begin
        hit0_a = we0 && (waddr0 == raddr_a);
        hit1_a = we1 && (waddr1 == raddr_a);
        hit0_b = we0 && (waddr0 == raddr_b);
        hit1_b = we1 && (waddr1 == raddr_b);
    end

    // Zero register first, then port 1 forward, then port 0 forward, then
    // stored value. Port 1 ahead of port 0 mirrors the write priority so a
    // forwarded value always equals what will be stored.
    always_comb begin
        if (ZR && (raddr_a == '0)) begin
            rdata_a = '0;
        end else if (BP && hit1_a) begin
            rdata_a = wdata1;
        end else if (BP && hit0_a) begin
            rdata_a = wdata0;
        end else begin
            rdata_a = mem[raddr_a];
        end
    end

    always_comb begin
        if (ZR && (raddr_b == '0)) begin
            rdata_b = '0;
        end else if (BP && hit1_b) begin
            rdata_b = wdata1;
        end else if (BP && hit0_b) begin
            rdata_b = wdata0;
        end else begin
            rdata_b = mem[raddr_b];
        end
    end

    // ---------------------------------------------------------------------
    // Busy outputs. A same-cycle writeback is forwarded when bypassing, so
    // the consumer need not stall for it.
    // ---------------------------------------------------------------------
    always_comb begin
        busy_a = busy[raddr_a];
        if (BP && (hit0_a || hit1_a)) begin
            busy_a = 1'b0;
        end
        if (ZR && (raddr_a == '0)) begin
            busy_a = 1'b0;
        end

        busy_b = busy[raddr_b];
        if (BP && (hit0_b || hit1_b)) begin
            busy_b = 1'b0;
        end
        if (ZR && (raddr_b == '0)) begin
            busy_b = 1'b0;
        end
    end

    // Drain status looks only at the registered vector.
    always_comb begin
        any_busy = |busy;
    end

endmodule

// File: tb/tb_regfile_2w2r_sb.sv
module tb_regfile_2w2r_sb;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;
    localparam int DEPTH  = 1 << ADDR_W;

    logic              clk;
    logic              clk_run;
    logic              rst;
    logic              we0;
    logic [ADDR_W-1:0] waddr0;
    logic [DATA_W-1:0] wdata0;
    logic              we1;
    logic [ADDR_W-1:0] waddr1;
    logic [DATA_W-1:0] wdata1;
    logic [ADDR_W-1:0] raddr_a;
    logic [ADDR_W-1:0] raddr_b;
    logic              issue_valid;
    logic [ADDR_W-1:0] issue_addr;

    // bypassing build
    logic [DATA_W-1:0] rdata_a;
    logic [DATA_W-1:0] rdata_b;
    logic              busy_a;
    logic              busy_b;
    logic              any_busy;

    // non-bypassing build
    logic [DATA_W-1:0] nb_rdata_a;
    logic [DATA_W-1:0] nb_rdata_b;
    logic              nb_busy_a;
    logic              nb_busy_b;
    logic              nb_any_busy;

    int n_tests;
    int n_fail;

    // reference state
    logic [DATA_W-1:0] ref_mem [DEPTH];
    bit                ref_busy [DEPTH];

    regfile_2w2r_sb #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .ZERO_REG(1), .BYPASS(1)) dut (
        .clk(clk), .rst(rst),
        .we0(we0), .waddr0(waddr0), .wdata0(wdata0),
        .we1(we1), .waddr1(waddr1), .wdata1(wdata1),
        .raddr_a(raddr_a), .rdata_a(rdata_a),
        .raddr_b(raddr_b), .rdata_b(rdata_b),
        .issue_valid(issue_valid), .issue_addr(issue_addr),
        .busy_a(busy_a), .busy_b(busy_b), .any_busy(any_busy)
    );

    regfile_2w2r_sb #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .ZERO_REG(1), .BYPASS(0)) dut_nb (
        .clk(clk), .rst(rst),
        .we0(we0), .waddr0(waddr0), .wdata0(wdata0),
        .we1(we1), .waddr1(waddr1), .wdata1(wdata1),
        .raddr_a(raddr_a), .rdata_a(nb_rdata_a),
        .raddr_b(raddr_b), .rdata_b(nb_rdata_b),
        .issue_valid(issue_valid), .issue_addr(issue_addr),
        .busy_a(nb_busy_a), .busy_b(nb_busy_b), .any_busy(nb_any_busy)
    );

    initial clk = 1'b0;
    always begin
        #5;
        if (clk_run) clk = ~clk;
    end

    task automatic check(input string tag, input logic [DATA_W-1:0] got,
                         input logic [DATA_W-1:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    task automatic model_reset();
        for (int i = 0; i < DEPTH; i++) begin
            ref_mem[i]  = '0;
            ref_busy[i] = 1'b0;
        end
    endtask

    // What a register holds / whether it is pending after this clock edge.
    task automatic model_clock();
        if (we1 && waddr1 != 0) ref_busy[waddr1] = 1'b0;
        if (we0 && waddr0 != 0) ref_busy[waddr0] = 1'b0;
        if (issue_valid && issue_addr != 0) ref_busy[issue_addr] = 1'b1;
        if (we0 && waddr0 != 0) ref_mem[waddr0] = wdata0;
        if (we1 && waddr1 != 0) ref_mem[waddr1] = wdata1;   // port 1 lands last
    endtask

    function automatic logic [DATA_W-1:0] model_read(input logic [ADDR_W-1:0] a, input bit byp);
        if (a == 0) return '0;
        if (byp && we1 && waddr1 == a) return wdata1;
        if (byp && we0 && waddr0 == a) return wdata0;
        return ref_mem[a];
    endfunction

    function automatic logic model_busy(input logic [ADDR_W-1:0] a, input bit byp);
        bit written;
        written = (we0 && waddr0 == a) || (we1 && waddr1 == a);
        if (a == 0) return 1'b0;
        if (byp && written) return 1'b0;
        return ref_busy[a];
    endfunction

    function automatic logic model_any();
        logic r;
        r = 1'b0;
        for (int i = 0; i < DEPTH; i++) r = r | ref_busy[i];
        return r;
    endfunction

    task automatic check_all(input string tag);
        check({tag, ".rda"},  rdata_a,  model_read(raddr_a, 1'b1));
        check({tag, ".rdb"},  rdata_b,  model_read(raddr_b, 1'b1));
        check({tag, ".ba"},   32'(busy_a),   32'(model_busy(raddr_a, 1'b1)));
        check({tag, ".bb"},   32'(busy_b),   32'(model_busy(raddr_b, 1'b1)));
        check({tag, ".any"},  32'(any_busy), 32'(model_any()));
        check({tag, ".nb_rda"}, nb_rdata_a, model_read(raddr_a, 1'b0));
        check({tag, ".nb_rdb"}, nb_rdata_b, model_read(raddr_b, 1'b0));
        check({tag, ".nb_ba"},  32'(nb_busy_a),   32'(model_busy(raddr_a, 1'b0)));
        check({tag, ".nb_bb"},  32'(nb_busy_b),   32'(model_busy(raddr_b, 1'b0)));
        check({tag, ".nb_any"}, 32'(nb_any_busy), 32'(model_any()));
    endtask

    task automatic idle_inputs();
        we0 = 0; we1 = 0; issue_valid = 0;
    endtask

    // One clock edge; inputs are stable across the edge and the model is
    // advanced with the same inputs the DUT sees.
    task automatic tick();
        @(posedge clk);
        model_clock();
        @(negedge clk);
    endtask

    logic [ADDR_W-1:0] ra;

    initial begin
        n_tests = 0; n_fail = 0;
        clk_run = 0; rst = 0;
        we0 = 0; waddr0 = 0; wdata0 = 0;
        we1 = 0; waddr1 = 0; wdata1 = 0;
        raddr_a = 7; raddr_b = 0;
        issue_valid = 0; issue_addr = 0;
        model_reset();

        // 1. reset with clock idle, then write
        #3 rst = 1;
        #2;
        check("t1.any_rst", 32'(any_busy), 32'd0);
        check("t1.rda_rst", rdata_a, 32'd0);
        rst = 0;
        #2 clk_run = 1;
        @(negedge clk);
        we0 = 1; waddr0 = 7; wdata0 = 32'h1234_5678;
        tick();
        idle_inputs(); raddr_a = 7;
        #1 check("t1.rda", rdata_a, 32'h1234_5678);
        check_all("t1");

        // 2. zero register
        we1 = 1; waddr1 = 0; wdata1 = 32'hFFFF_FFFF; raddr_a = 0;
        issue_valid = 1; issue_addr = 0;
        #1 check("t2.rda_same", rdata_a, 32'd0);
        check_all("t2a");
        tick();
        idle_inputs();
        #1 check("t2.rda_after", rdata_a, 32'd0);
        check("t2.busy_a", 32'(busy_a), 32'd0);
        check("t2.any", 32'(any_busy), 32'd0);

        // 3. dual-write collision
        we0 = 1; waddr0 = 5; wdata0 = 32'hAAAA_AAAA;
        we1 = 1; waddr1 = 5; wdata1 = 32'h5555_5555; raddr_b = 5;
        #1 check("t3.rdb_byp", rdata_b, 32'h5555_5555);
        check("t3.nb_rdb_old", nb_rdata_b, 32'd0);
        tick();
        idle_inputs();
        #1 check("t3.rdb_after", rdata_b, 32'h5555_5555);
        check("t3.nb_rdb_after", nb_rdata_b, 32'h5555_5555);

        // 4. bypass off
        we0 = 1; waddr0 = 9; wdata0 = 32'h11;
        tick();
        we0 = 1; waddr0 = 9; wdata0 = 32'h22; raddr_a = 9;
        #1 check("t4.nb_rda_same", nb_rdata_a, 32'h11);
        check("t4.rda_same_byp", rdata_a, 32'h22);
        tick();
        idle_inputs();
        #1 check("t4.nb_rda_next", nb_rdata_a, 32'h22);

        // 5. scoreboard lifecycle
        issue_valid = 1; issue_addr = 12;
        tick();
        idle_inputs(); raddr_a = 12;
        #1 check("t5.busy_a", 32'(busy_a), 32'd1);
        check("t5.any", 32'(any_busy), 32'd1);
        we1 = 1; waddr1 = 12; wdata1 = 32'hBEEF;
        #1 check("t5.busy_a_wr", 32'(busy_a), 32'd0);
        check("t5.rda_wr", rdata_a, 32'hBEEF);
        check("t5.nb_busy_a_wr", 32'(nb_busy_a), 32'd1);
        tick();
        idle_inputs();
        #1 check("t5.any_after", 32'(any_busy), 32'd0);
        check_all("t5");

        // 6. issue/write race, then async reset
        issue_valid = 1; issue_addr = 3;
        tick();
        idle_inputs();
        we0 = 1; waddr0 = 3; wdata0 = 32'h77;
        issue_valid = 1; issue_addr = 3;
        tick();
        idle_inputs(); raddr_a = 3;
        #1 check("t6.busy_race", 32'(busy_a), 32'd1);
        check("t6.rda_race", rdata_a, 32'h77);
        rst = 1; model_reset();
        #1 check("t6.busy_rst", 32'(busy_a), 32'd0);
        check("t6.any_rst", 32'(any_busy), 32'd0);
        check("t6.rda_rst", rdata_a, 32'd0);
        rst = 0;

        // randomized traffic against the model
        for (int cyc = 0; cyc < 600; cyc++) begin
            @(negedge clk);
            we0 = ($urandom_range(0, 2) == 0);
            we1 = ($urandom_range(0, 2) == 0);
            issue_valid = ($urandom_range(0, 2) == 0);
            ra = ($urandom_range(0, 3) == 0) ? ADDR_W'($urandom_range(0, DEPTH-1))
                                             : ADDR_W'($urandom_range(0, 7));
            waddr0 = ra;
            waddr1 = ADDR_W'($urandom_range(0, 7));
            issue_addr = ADDR_W'($urandom_range(0, 7));
            raddr_a = ADDR_W'($urandom_range(0, 7));
            raddr_b = ($urandom_range(0, 1) == 0) ? waddr0 : ADDR_W'($urandom_range(0, 7));
            wdata0 = $urandom;
            wdata1 = $urandom;
            #1 check_all("rnd");
            if ($urandom_range(0, 60) == 0) begin
                rst = 1; model_reset();
                #1 check_all("rnd_rst");
                rst = 0;
                #1;
            end
            @(posedge clk);
            model_clock();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
